// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for the shared ALU: two requesters, one
// transaction in flight, registered operands and a backpressured response.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    // Handshakes: a request transfers on an edge where reqN_valid & reqN_ready;
    // a response transfers where rsp[owner]_valid & rsp[owner]_ready. A valid
    // once raised stays high until its transfer; ready may be low any cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant0;
    logic   grant1;
    logic   accept;
    logic   rsp_take;

    // On a tie the port that did not win last time is served.
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign rsp_take   = owner ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 2'b00;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= grant1 ? req1_a  : req0_a;
                        alu_b      <= grant1 ? req1_b  : req0_b;
                        alu_op     <= grant1 ? req1_op : req0_op;
                        owner      <= grant1;
                        last_grant <= grant1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // alu_* have been stable for this whole cycle; sample the result.
                    rsp_result <= alu_result;
                    rsp_zero   <= (alu_result == '0);
                    if (owner) rsp1_valid <= 1'b1;
                    else       rsp0_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        op_count   <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU (2-bit op: 00 add, 01 sub, 10 or, 11 and) in the multi-cycle CPU. It accepts operand/op requests over valid/ready handshakes and drives registered operands into the ALU. It holds them stable for one full execute cycle, captures the result and zero flag, and returns them to the winning requester on a backpressured response channel. It sits between the control unit (port 0), the display/debug path (port 1) and the ALU instance.

## Interface
- WIDTH, 32, datapath width of operands and result
- CNT_W, 16, width of completed-operation counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  request N presents operands (N = 0, 1)
- reqN_ready  out  1  arbiter accepts request N this cycle
- reqN_a, reqN_b  in  WIDTH  operands for request N
- reqN_op  in  2  ALU op for request N
- rspN_valid  out  1  result for request N available
- rspN_ready  in  1  requester N takes result
- rsp_result  out  WIDTH  captured ALU result (shared by both ports)
- rsp_zero  out  1  captured result == 0
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_op  out  2  registered op to ALU
- alu_result  in  WIDTH  ALU output
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed transactions, wraps mod 2^CNT_W

## Operation
- FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
- IDLE: grant computed combinationally from valids.
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high.
- IDLE to EXEC on accept (reqN_valid & reqN_ready):
  - latch reqN_a/b/op into alu_a/alu_b/alu_op;
  - record owner = N; last_grant = N.
- EXEC to RESP after exactly one cycle:
  - rsp_result <= alu_result; rsp_zero <= (alu_result == 0);
  - rsp[owner]_valid <= 1.
- RESP: hold rsp_result, rsp_zero, rspN_valid and the alu_* registers stable until rsp[owner]_ready.
  - On valid & ready: rspN_valid <= 0, op_count += 1, state <= IDLE.
  - rsp_ready of the non-owner port is ignored.
- Arithmetic is the ALU's: add/sub modulo 2^WIDTH, no carry or overflow output. The arbiter does not modify data.
- alu_* registers change only on accept. Between transactions they hold the last values.
- Requests never drop: a valid that is not granted must stay asserted. The arbiter keeps no request state beyond last_grant.

## Timing
- Reset (async, rst_n low): state IDLE, last_grant = 1 (port 0 wins the first tie), owner 0.
  - Cleared to 0: all rspN_valid, rsp_result, rsp_zero, alu_a, alu_b, alu_op, op_count.
  - busy = 0. reqN_ready follows IDLE rules combinationally, so it is 0 while no request is valid.
- Accept at edge E0 → alu_* valid after E0 → result captured at E1 → rspN_valid high after E1. Latency is 1 cycle from accept to response valid.
- Response taken at edge E2 (earliest) → IDLE after E2 → next accept at E3. Peak throughput is 1 op per 3 cycles.
- Reset mid-EXEC or mid-RESP: transaction discarded, no response, op_count not incremented.
- Requests arriving in EXEC/RESP wait (ready = 0). Arbitration resolves in the first IDLE cycle.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan
- Port 0 add: req0 a=5, b=3, op=00, rsp0_ready=1 → rsp0_valid exactly 1 cycle after accept, rsp_result=8, rsp_zero=0, op_count=1, busy high for 2 cycles.
- Port 1 sub boundaries: 7-7 → result 0, zero=1. Then 0-1 → 0xFFFFFFFF, zero=0. Then or 0xF0|0x0F → 0xFF. Then and 0xF0&0x0F → 0, zero=1. Each response goes on rsp1 only; rsp0_valid stays 0.
- Tie: both ports valid continuously from reset, each issuing 4 ops → grant order 0,1,0,1,0,1,0,1. reqN_ready never high on both ports; op_count=8.
- Backpressure: rsp0_ready low 5 cycles after rsp0_valid → rsp0_valid, rsp_result, rsp_zero and alu_* stable throughout. req1 held valid is not accepted until 1 cycle after the rsp0 handshake.
- Reset mid-op: assert rst_n low during EXEC → all outputs 0 immediately, no rsp valid after release. Next tie is granted to port 0.
- Wrap: CNT_W=4, 17 completed ops → op_count=1.
